// File: rtl/bfloat16_fma_seq.sv
// rtl/bfloat16_fma_seq.sv - command sequencer feeding a combinational bf16 FMA core
//
// Buffers FMA commands, drives the core from stable registers for a settle
// interval, then captures the tagged result and flags into a result FIFO.
//
// Ports:
//   clk, reset_n (sync, active-low), flush
//   cmd_valid/cmd_ready, cmd_tag, cmd_ctrl, cmd_op, cmd_rm, cmd_a/b/c : command in
//   fma_control, fma_op, fma_rm, fma_a/b/c                            : core drive
//   fma_out, fma_flags                                                : core result
//   res_valid/res_ready, res_tag, res_data, res_flags                 : result out
//   busy, cmd_count, res_count, op_count                              : status
module bfloat16_fma_seq #(
  parameter int CMD_DEPTH  = 4,
  parameter int RES_DEPTH  = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [3:0]                   cmd_tag,
  input  logic                         cmd_ctrl,
  input  logic [1:0]                   cmd_op,
  input  logic [2:0]                   cmd_rm,
  input  logic [15:0]                  cmd_a,
  input  logic [15:0]                  cmd_b,
  input  logic [15:0]                  cmd_c,
  output logic                         fma_control,
  output logic [1:0]                   fma_op,
  output logic [2:0]                   fma_rm,
  output logic [15:0]                  fma_a,
  output logic [15:0]                  fma_b,
  output logic [15:0]                  fma_c,
  input  logic [15:0]                  fma_out,
  input  logic [4:0]                   fma_flags,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [3:0]                   res_tag,
  output logic [15:0]                  res_data,
  output logic [4:0]                   res_flags,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   cmd_count,
  output logic [$clog2(RES_DEPTH):0]   res_count,
  output logic [15:0]                  op_count
);

  localparam int CW = $clog2(CMD_DEPTH);
  localparam int RW = $clog2(RES_DEPTH);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, CAPTURE = 2'd2} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] cnt, cnt_nx;
  logic [3:0]    tag_q;

  // command entry: {tag, ctrl, op, rm, a, b, c}
  logic [57:0]   cmd_mem [CMD_DEPTH];
  logic [CW-1:0] cmd_wp, cmd_rp;
  logic [57:0]   cmd_head;

  // result entry: {tag, data, flags}
  logic [24:0]   res_mem [RES_DEPTH];
  logic [RW-1:0] res_wp, res_rp;

  logic cmd_full, res_full, cmd_push, issue, capture, res_pop;

  assign cmd_full  = (cmd_count == (CW+1)'(CMD_DEPTH));
  assign res_full  = (res_count == (RW+1)'(RES_DEPTH));
  assign cmd_ready = !cmd_full && !flush && reset_n;
  assign cmd_push  = cmd_valid && cmd_ready;
  // Issue waits for result space so a capture can never be blocked.
  assign issue     = (state == IDLE) && (cmd_count != '0) && !res_full;
  assign capture   = (state == CAPTURE);
  assign res_valid = (res_count != '0);
  assign res_pop   = res_valid && res_ready;
  assign busy      = (state != IDLE);
  assign cmd_head  = cmd_mem[cmd_rp];

  // Head is masked while empty so stale storage never shows on the outputs.
  assign {res_tag, res_data, res_flags} = res_valid ? res_mem[res_rp] : 25'd0;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (issue) begin
          state_nx = SETTLE;
          cnt_nx   = SW'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        if (cnt == '0) state_nx = CAPTURE;
        else           cnt_nx   = cnt - SW'(1);
      end
      CAPTURE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp] <= {cmd_tag, cmd_ctrl, cmd_op, cmd_rm, cmd_a, cmd_b, cmd_c};
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      cmd_wp    <= '0;
      cmd_rp    <= '0;
      cmd_count <= '0;
    end else begin
      if (cmd_push) cmd_wp <= cmd_wp + CW'(1);
      if (issue)    cmd_rp <= cmd_rp + CW'(1);
      cmd_count <= cmd_count + (CW+1)'(cmd_push) - (CW+1)'(issue);
    end
  end

  // Core drive registers hold through flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {tag_q, fma_control, fma_op, fma_rm, fma_a, fma_b, fma_c} <= '0;
    end else if (issue && !flush) begin
      {tag_q, fma_control, fma_op, fma_rm, fma_a, fma_b, fma_c} <= cmd_head;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) res_mem[res_wp] <= {tag_q, fma_out, fma_flags};
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      res_wp    <= '0;
      res_rp    <= '0;
      res_count <= '0;
    end else begin
      if (capture) res_wp <= res_wp + RW'(1);
      if (res_pop) res_rp <= res_rp + RW'(1);
      res_count <= res_count + (RW+1)'(capture) - (RW+1)'(res_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                op_count <= '0;
    else if (capture && !flush)  op_count <= op_count + 16'd1;
  end

endmodule

// File: tb/tb_bfloat16_fma_seq.sv
// tb/tb_bfloat16_fma_seq.sv - self-checking bench for bfloat16_fma_seq
module tb_bfloat16_fma_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, flush, cmd_valid, cmd_ready;
  logic [3:0]  cmd_tag;
  logic        cmd_ctrl;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rm;
  logic [15:0] cmd_a, cmd_b, cmd_c;
  logic        fma_control;
  logic [1:0]  fma_op;
  logic [2:0]  fma_rm;
  logic [15:0] fma_a, fma_b, fma_c, fma_out;
  logic [4:0]  fma_flags;
  logic        res_valid, res_ready;
  logic [3:0]  res_tag;
  logic [15:0] res_data;
  logic [4:0]  res_flags;
  logic        busy;
  logic [2:0]  cmd_count, res_count;
  logic [15:0] op_count;

  typedef struct {
    logic [3:0]  tag;
    logic        ctrl;
    logic [1:0]  op;
    logic [2:0]  rm;
    logic [15:0] a, b, c;
    logic [24:0] exp;
  } vec_t;

  // Stand-in for the combinational core: any deterministic function of the drive.
  function automatic logic [20:0] core_model(input logic ctrl, input logic [1:0] op,
                                             input logic [2:0] rm, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] c);
    logic [15:0] o;
    o = (a + {b[7:0], b[15:8]}) ^ c ^ {ctrl, op, rm, 10'h0};
    return {o, a[4:0] ^ c[15:11] ^ {rm, op}};
  endfunction

  function automatic logic [24:0] expect_of(input vec_t v);
    return {v.tag, core_model(v.ctrl, v.op, v.rm, v.a, v.b, v.c)};
  endfunction

  assign {fma_out, fma_flags} = core_model(fma_control, fma_op, fma_rm, fma_a, fma_b, fma_c);

  bfloat16_fma_seq #(.CMD_DEPTH(4), .RES_DEPTH(4), .SETTLE_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag), .cmd_ctrl(cmd_ctrl),
    .cmd_op(cmd_op), .cmd_rm(cmd_rm), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c),
    .fma_control(fma_control), .fma_op(fma_op), .fma_rm(fma_rm),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_out(fma_out), .fma_flags(fma_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_data(res_data), .res_flags(res_flags),
    .busy(busy), .cmd_count(cmd_count), .res_count(res_count), .op_count(op_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 0; cmd_valid = 0; res_ready = 0;
    cmd_tag = 0; cmd_ctrl = 0; cmd_op = 0; cmd_rm = 0;
    cmd_a = 0; cmd_b = 0; cmd_c = 0;
  endtask

  task automatic rst();
    idle_inputs();
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  task automatic drive(input vec_t v);
    cmd_valid = 1; cmd_tag = v.tag; cmd_ctrl = v.ctrl; cmd_op = v.op;
    cmd_rm = v.rm; cmd_a = v.a; cmd_b = v.b; cmd_c = v.c;
  endtask

  function automatic vec_t mk(input logic [3:0] tag, input logic ctrl, input logic [1:0] op,
                              input logic [2:0] rm, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] c);
    vec_t v;
    v.tag = tag; v.ctrl = ctrl; v.op = op; v.rm = rm; v.a = a; v.b = b; v.c = c;
    v.exp = expect_of(v);
    return v;
  endfunction

  // Scoreboard: accepted commands in order; a flush discards everything outstanding.
  logic [24:0] exp_q[$];

  task automatic rand_cycles(input int n, input bit drain);
    vec_t v;
    logic acc, pop;
    for (int i = 0; i < n; i++) begin
      if (drain) begin
        cmd_valid = 0; flush = 0; res_ready = 1;
      end else begin
        cmd_valid = 1'($urandom_range(0, 1));
        res_ready = ($urandom_range(0, 9) < 6);
        flush     = ($urandom_range(0, 49) == 0);
        v = mk(4'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
               16'($urandom), 16'($urandom), 16'($urandom));
        cmd_tag = v.tag; cmd_ctrl = v.ctrl; cmd_op = v.op; cmd_rm = v.rm;
        cmd_a = v.a; cmd_b = v.b; cmd_c = v.c;
      end
      #1;
      acc = cmd_valid && cmd_ready;
      pop = res_valid && res_ready;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (pop) begin
          if (exp_q.size() == 0) chk("rand_unexpected_result", 1, 0);
          else chk("rand_result", {res_tag, res_data, res_flags}, exp_q.pop_front());
        end
        if (acc) exp_q.push_back(expect_of(v));
      end
      tick();
    end
  endtask

  vec_t tbl[4];
  vec_t s1, s5, s6, s7;
  int lat, n, last, acc, w;
  logic seen;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(4'd0, 1'b0, 2'd1, 3'd2, 16'h3F80, 16'h4040, 16'hBF00);
    tbl[1] = mk(4'd1, 1'b1, 2'd0, 3'd1, 16'h7F7F, 16'h0001, 16'h8000);
    tbl[2] = mk(4'd2, 1'b0, 2'd3, 3'd4, 16'h0000, 16'hFFFF, 16'h7FC0);
    tbl[3] = mk(4'd3, 1'b1, 2'd2, 3'd7, 16'hC2F6, 16'h3DCC, 16'h4120);
    s1 = mk(4'd3, 1'b0, 2'd0, 3'd0, 16'h3F80, 16'h4000, 16'h3F80);

    // reset state
    idle_inputs();
    reset_n = 0;
    tick(); tick();
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_counts", {cmd_count, res_count, op_count}, 0);
    chk("reset_fma", {fma_control, fma_op, fma_rm, fma_a, fma_b, fma_c}, 0);
    chk("reset_res_head", {res_tag, res_data, res_flags}, 0);
    reset_n = 1;
    #1 chk("ready_after_reset", cmd_ready, 1);

    // single op latency
    drive(s1); tick(); cmd_valid = 0;
    chk("single_cmd_count", cmd_count, 1);
    tick();
    chk("single_fma_drive", {fma_a, fma_b, fma_c}, {16'h3F80, 16'h4000, 16'h3F80});
    chk("single_busy", busy, 1);
    lat = 1;
    while (!res_valid && lat < 12) begin tick(); lat++; end
    chk("single_latency", lat, 4);
    chk("single_result", {res_tag, res_data, res_flags}, s1.exp);
    chk("single_op_count", op_count, 1);
    chk("single_idle", busy, 0);
    res_ready = 1; tick(); res_ready = 0;
    chk("single_popped", {res_valid, res_count}, 0);

    // back-to-back table vectors
    res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i]);
      #1 chk("b2b_cmd_ready", cmd_ready, 1);
      tick();
    end
    cmd_valid = 0;
    n = 0; last = 0;
    for (int cyc = 1; cyc <= 40 && n < 4; cyc++) begin
      tick();
      if (res_valid) begin
        chk("b2b_result", {res_tag, res_data, res_flags}, tbl[n].exp);
        if (n > 0) chk("b2b_spacing", cyc - last, 4);
        last = cyc;
        n++;
      end
    end
    chk("b2b_all_results", n, 4);
    chk("b2b_op_count", op_count, 5);
    res_ready = 0;

    // command FIFO full with stalled consumer
    rst();
    acc = 0;
    cmd_valid = 1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      cmd_tag = 4'(acc); cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_c = 16'($urandom);
      #1;
      if (cmd_ready && acc < 9) acc++;
      if (acc == 9) cmd_valid = 0;
      tick();
    end
    cmd_valid = 0;
    chk("full_accepted", acc, 8);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_busy", busy, 0);
    chk("full_counts", {res_count, cmd_count}, {3'd4, 3'd4});
    chk("full_head_tag", res_tag, 0);
    res_ready = 1; tick(); res_ready = 0;
    chk("full_after_pop", {res_tag, res_count}, {4'd1, 3'd3});
    repeat (12) tick();
    chk("full_one_more", {res_count, cmd_count}, {3'd4, 3'd3});
    chk("full_op_count", op_count, 5);

    // pop and capture on the same edge
    rst();
    s5 = mk(4'd5, 1'b0, 2'd1, 3'd3, 16'h1234, 16'h5678, 16'h9ABC);
    s6 = mk(4'd6, 1'b1, 2'd2, 3'd5, 16'hDEAD, 16'hBEEF, 16'h0F0F);
    s7 = mk(4'd7, 1'b0, 2'd3, 3'd6, 16'h4049, 16'h402D, 16'hC000);
    drive(s5); tick(); drive(s6); tick(); drive(s7); tick(); cmd_valid = 0;
    w = 0;
    while (!(res_count == 2 && busy) && w < 40) begin tick(); w++; end
    chk("pc_reached_third_issue", w < 40, 1);
    tick(); tick();
    chk("pc_in_capture", {busy, res_count}, {1'b1, 3'd2});
    res_ready = 1; tick();
    chk("pc_count_held", res_count, 2);
    chk("pc_op_count", op_count, 3);
    chk("pc_order_6", {res_tag, res_data, res_flags}, s6.exp);
    tick();
    chk("pc_order_7", {res_tag, res_data, res_flags}, s7.exp);
    tick();
    chk("pc_drained", res_valid, 0);
    res_ready = 0;

    // flush during SETTLE with two queued (op_count already 3)
    drive(mk(4'd8, 1'b0, 2'd0, 3'd0, 16'h1111, 16'h2222, 16'h3333)); tick();
    drive(mk(4'd9, 1'b0, 2'd0, 3'd0, 16'h4444, 16'h5555, 16'h6666)); tick();
    drive(mk(4'd10, 1'b0, 2'd0, 3'd0, 16'h7777, 16'h8888, 16'h9999)); tick();
    cmd_valid = 0;
    chk("flush_pre", {busy, cmd_count}, {1'b1, 3'd2});
    flush = 1; tick(); flush = 0;
    chk("flush_state", {busy, cmd_count, res_count}, 0);
    chk("flush_op_count", op_count, 3);
    chk("flush_fma_hold", fma_a, 16'h1111);
    seen = 0;
    repeat (12) begin tick(); if (res_valid) seen = 1; end
    chk("flush_no_result", seen, 0);
    chk("flush_op_count_later", op_count, 3);

    // reset during CAPTURE
    drive(mk(4'd12, 1'b1, 2'd1, 3'd1, 16'hAAAA, 16'h5555, 16'h0F0F)); tick(); cmd_valid = 0;
    tick(); tick(); tick();
    chk("rst_in_capture", busy, 1);
    reset_n = 0; tick();
    chk("rst_mid_status", {cmd_ready, res_valid, busy, cmd_count, res_count, op_count}, 0);
    chk("rst_mid_fma", {fma_control, fma_op, fma_rm, fma_a, fma_b, fma_c}, 0);
    chk("rst_mid_head", {res_tag, res_data, res_flags}, 0);
    reset_n = 1;
    drive(s1); tick(); cmd_valid = 0;
    lat = 0;
    while (!res_valid && lat < 12) begin tick(); lat++; end
    chk("rst_recover_result", {res_tag, res_data, res_flags}, s1.exp);
    chk("rst_recover_op_count", op_count, 1);
    res_ready = 1; tick(); res_ready = 0;

    // op_count wrap
    force dut.op_count = 16'hFFFF;
    #1 release dut.op_count;
    drive(tbl[2]); tick(); cmd_valid = 0;
    lat = 0;
    while (!res_valid && lat < 12) begin tick(); lat++; end
    chk("wrap_result", {res_tag, res_data, res_flags}, tbl[2].exp);
    chk("wrap_op_count", op_count, 0);
    res_ready = 1; tick(); res_ready = 0;

    // randomized traffic against the scoreboard
    rst();
    exp_q.delete();
    rand_cycles(600, 1'b0);
    rand_cycles(60, 1'b1);
    chk("rand_all_delivered", exp_q.size(), 0);
    chk("rand_empty", {res_valid, busy, cmd_count, res_count}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bfloat16_fma_seq.md
# bfloat16_fma_seq

Command sequencer that sits directly upstream of the combinational bfloat16 FMA core and feeds it one operation at a time. It buffers incoming FMA commands in a command FIFO and drives the core's operand, op and rounding-mode inputs from stable registers. It waits a fixed settle interval for the core's combinational path, then captures the core's result and exception flags, tagged, into a result FIFO for downstream consumers.

## Interface
- CMD_DEPTH, 4: command FIFO entries (power of two, ≥2)
- RES_DEPTH, 4: result FIFO entries (power of two, ≥2)
- SETTLE_CYC, 2: cycles operands are held before capture (≥1)
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- flush  in  1  discard all queued and in-flight work
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO can accept
- cmd_tag  in  4  opaque tag returned with result
- cmd_ctrl  in  1  core control bit
- cmd_op  in  2  core op select
- cmd_rm  in  3  rounding mode
- cmd_a, cmd_b, cmd_c  in  16 each  bf16 operands
- fma_control  out  1; fma_op  out  2; fma_rm  out  3; fma_a, fma_b, fma_c  out  16 each  registered drive to core
- fma_out  in  16  core result
- fma_flags  in  5  core exception flags
- res_valid  out  1  result FIFO non-empty
- res_ready  in  1  consumer pops head
- res_tag  out  4; res_data  out  16; res_flags  out  5  head of result FIFO
- busy  out  1  FSM not IDLE
- cmd_count  out  log2(CMD_DEPTH)+1  command FIFO occupancy
- res_count  out  log2(RES_DEPTH)+1  result FIFO occupancy
- op_count  out  16  completed operations, wraps 0xFFFF→0

## Operation
- Reset (reset_n=0 at an edge): both FIFOs empty, FSM IDLE, all fma_* outputs 0, res_valid 0, res_tag/res_data/res_flags 0, busy 0, counts 0, op_count 0, cmd_ready 0 while reset_n=0.
- Command push: cmd_valid && cmd_ready at an edge. cmd_ready = !cmd_full && !flush && reset_n; no bypass, so a full FIFO rejects a push even when a pop occurs in the same cycle.
- FSM states:
  - IDLE: if command FIFO non-empty and result FIFO not full, pop head, load fma_* registers and an internal tag register, set cnt=SETTLE_CYC-1, go SETTLE. Otherwise stay.
  - SETTLE: fma_* held constant. If cnt==0 go CAPTURE, else cnt--.
  - CAPTURE: write {tag, fma_out, fma_flags} into result FIFO, op_count++, go IDLE.
- At most one operation is in flight. Issue is gated on result-FIFO space, so CAPTURE never finds the result FIFO full.
- fma_* retain the last issued values in IDLE and do not return to 0.
- Result pop: res_valid && res_ready at an edge. A pop and a CAPTURE write in the same cycle are both honoured; occupancy is unchanged.
- res_ready with res_valid=0 is ignored. Pops never underflow.
- flush=1 at an edge:
  - Empties both FIFOs and forces the FSM to IDLE, dropping any in-flight op (no capture, op_count unchanged).
  - Takes priority over a same-cycle push, pop or capture.
  - fma_* hold their values.
- reset_n=0 mid-operation behaves identically to flush and additionally zeroes fma_* and op_count.

## Timing
- Min latency with SETTLE_CYC=2, both FIFOs empty:
  - Command accepted at edge 0.
  - IDLE pops at edge 1; fma_* valid from edge 1.
  - SETTLE spans edges 2–3; CAPTURE writes at edge 4.
  - res_valid high after edge 4.
  - General latency: SETTLE_CYC+2 edges.
- Throughput: one op per SETTLE_CYC+2 cycles with a backlog (IDLE + SETTLE_CYC + CAPTURE).
- busy is 1 in SETTLE and CAPTURE, and 0 in IDLE.
- Counts reflect registered state after each edge.

## Test plan
- Single op: after reset, push tag=3, op=0, a=0x3F80, b=0x4000, c=0x3F80. Result must show res_valid rising exactly 4 edges after the push, with res_tag=3 and res_data/res_flags equal to the core's output for those operands, and op_count=1.
- Back-to-back: push 4 commands with tags 0–3 on consecutive edges, res_ready=1. Results must emerge in tag order 0,1,2,3 spaced 4 cycles apart. cmd_ready stays 1 throughout.
- Command full: hold res_ready=0 with RES_DEPTH=4. Push 9 commands. Exactly 8 are accepted (4 results + 4 queued), after which cmd_ready=0, busy=0, res_count=4 and cmd_count=4. Pop one result, and exactly one more op issues.
- Simultaneous pop and capture: with res_count=2 and res_ready held 1, at the CAPTURE edge res_count must remain 2 and FIFO order must be preserved.
- Flush mid-op: assert flush during SETTLE with 2 commands queued. The next edge must give busy=0, cmd_count=0, res_count=0, op_count unchanged, and no result ever appears.
- Reset mid-op: pull reset_n=0 in CAPTURE. All outputs must return to their reset values. After release, a new push completes normally with op_count=1. Also check op_count wrap from 0xFFFF to 0 (preload via forced state).
